// File: rtl/dualmem_param_if.sv
// Bus bundle for dualmem_param: both access ports plus status outputs.
// master = requester side, slave = RAM side.
interface dualmem_param_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 13,
  parameter int BYTE_W = 8
);
  localparam int NB = DATA_W / BYTE_W;

  logic              init_done;
  logic              ena;
  logic [NB-1:0]     wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;
  logic              rvalida;
  logic              enb;
  logic [NB-1:0]     web;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] dinb;
  logic [DATA_W-1:0] doutb;
  logic              rvalidb;
  logic              collision;

  modport master (
    input  init_done, douta, rvalida, doutb, rvalidb, collision,
    output ena, wea, addra, dina, enb, web, addrb, dinb
  );

  modport slave (
    output init_done, douta, rvalida, doutb, rvalidb, collision,
    input  ena, wea, addra, dina, enb, web, addrb, dinb
  );
endinterface

// File: rtl/dualmem_param.sv
// Parametrised single-clock true dual-port RAM with byte-lane writes,
// per-port read-valid strobes, selectable same-port read-during-write,
// deterministic same-address collision handling (port A wins shared lanes)
// and an optional zero-initialisation sequencer after reset.
// Optional macro DUALMEM_OUTREG_EN adds an output register stage
// (read latency 2, collision delayed to stay aligned with rvalid).
module dualmem_param #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 13,
  parameter int BYTE_W    = 8,
  parameter int RDW_MODE  = 0,
  parameter int INIT_ZERO = 1
) (
  input logic            clk,
  input logic            rst,
  dualmem_param_if.slave bus
);
  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            state_q, state_n;
  logic              ready;
  logic [ADDR_W-1:0] init_cnt_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // Replace the lanes selected by we with the corresponding lanes of new_w.
  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [NB-1:0]     we);
    lane_merge = old_w;
    for (int i = 0; i < NB; i++) begin
      if (we[i]) lane_merge[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    end
  endfunction

  // FSM state and init address counter; the counter restarts on every reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
      init_cnt_q <= '0;
    end else begin
      state_q <= state_n;
      if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + 1'b1;
    end
  end

  // Next state: leave INIT after the last word has been cleared
  always_comb begin
    state_n = state_q;
    ready   = 1'b0;
    case (state_q)
      ST_INIT:  if (init_cnt_q == '1) state_n = ST_READY;
      ST_READY: ready = 1'b1;
      default:  state_n = ST_INIT;
    endcase
  end

  // ---- stage p0: access qualification, write muxing, array read ----
  logic              acc_a_p0, acc_b_p0, init_wr_p0, coll_p0;
  logic [NB-1:0]     wr_a_p0, wr_b_p0;
  logic [ADDR_W-1:0] waddr_a_p0;
  logic [DATA_W-1:0] wdata_a_p0, rd_a_p0, rd_b_p0;

  assign acc_a_p0   = bus.ena & ready & ~rst;
  assign acc_b_p0   = bus.enb & ready & ~rst;
  assign init_wr_p0 = (state_q == ST_INIT) & ~rst;
  // Port A's write path doubles as the zero-init path while in INIT.
  assign wr_a_p0    = init_wr_p0 ? {NB{1'b1}} : (acc_a_p0 ? bus.wea : '0);
  assign wr_b_p0    = acc_b_p0 ? bus.web : '0;
  assign waddr_a_p0 = init_wr_p0 ? init_cnt_q : bus.addra;
  assign wdata_a_p0 = init_wr_p0 ? '0 : bus.dina;
  assign coll_p0    = acc_a_p0 & acc_b_p0 & (bus.addra == bus.addrb) &
                      ((|bus.wea) | (|bus.web));

  // Array write: port B first so port A's data wins on shared lanes
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_b_p0[i]) mem[bus.addrb][i*BYTE_W +: BYTE_W] <= bus.dinb[i*BYTE_W +: BYTE_W];
      if (wr_a_p0[i]) mem[waddr_a_p0][i*BYTE_W +: BYTE_W] <= wdata_a_p0[i*BYTE_W +: BYTE_W];
    end
  end

  // Read word: pre-write contents, or own-port merged word in write-first mode
  always_comb begin
    rd_a_p0 = mem[bus.addra];
    rd_b_p0 = mem[bus.addrb];
    if (RDW_MODE == 1) begin
      rd_a_p0 = lane_merge(rd_a_p0, bus.dina, bus.wea);
      rd_b_p0 = lane_merge(rd_b_p0, bus.dinb, bus.web);
    end
  end

  // ---- stage p1: read data holds while idle, strobes pulse per access ----
  logic [DATA_W-1:0] douta_p1, doutb_p1;
  logic              vld_a_p1, vld_b_p1, coll_p1;

  // Registered read data and one-cycle strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      douta_p1 <= '0;
      doutb_p1 <= '0;
      vld_a_p1 <= 1'b0;
      vld_b_p1 <= 1'b0;
      coll_p1  <= 1'b0;
    end else begin
      vld_a_p1 <= acc_a_p0;
      vld_b_p1 <= acc_b_p0;
      coll_p1  <= coll_p0;
      if (acc_a_p0) douta_p1 <= rd_a_p0;
      if (acc_b_p0) doutb_p1 <= rd_b_p0;
    end
  end

`ifdef DUALMEM_OUTREG_EN
  // ---- stage p2: extra output register, everything delayed together ----
  logic [DATA_W-1:0] douta_p2, doutb_p2;
  logic              vld_a_p2, vld_b_p2, coll_p2;

  // Output register stage for timing closure
  always_ff @(posedge clk) begin
    if (rst) begin
      douta_p2 <= '0;
      doutb_p2 <= '0;
      vld_a_p2 <= 1'b0;
      vld_b_p2 <= 1'b0;
      coll_p2  <= 1'b0;
    end else begin
      douta_p2 <= douta_p1;
      doutb_p2 <= doutb_p1;
      vld_a_p2 <= vld_a_p1;
      vld_b_p2 <= vld_b_p1;
      coll_p2  <= coll_p1;
    end
  end

  assign bus.douta     = douta_p2;
  assign bus.doutb     = doutb_p2;
  assign bus.rvalida   = vld_a_p2;
  assign bus.rvalidb   = vld_b_p2;
  assign bus.collision = coll_p2;
`else
  assign bus.douta     = douta_p1;
  assign bus.doutb     = doutb_p1;
  assign bus.rvalida   = vld_a_p1;
  assign bus.rvalidb   = vld_b_p1;
  assign bus.collision = coll_p1;
`endif

  assign bus.init_done = ready;
endmodule

// File: tb/tb_dualmem_param.sv
// Testbench for dualmem_param: two instances (read-first and write-first),
// both with zero-init and a 16-word array, driven with identical stimulus
// and compared every cycle against a word-level reference model.
module tb_dualmem_param;
  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int BW    = 8;
  localparam int NB    = DW / BW;
  localparam int DEPTH = 2 ** AW;
`ifdef DUALMEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ena, enb;
  logic [NB-1:0] wea, web;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb;

  dualmem_param_if #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(BW)) bus0 ();
  dualmem_param_if #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(BW)) bus1 ();

  assign bus0.ena = ena;   assign bus1.ena = ena;
  assign bus0.wea = wea;   assign bus1.wea = wea;
  assign bus0.addra = addra; assign bus1.addra = addra;
  assign bus0.dina = dina; assign bus1.dina = dina;
  assign bus0.enb = enb;   assign bus1.enb = enb;
  assign bus0.web = web;   assign bus1.web = web;
  assign bus0.addrb = addrb; assign bus1.addrb = addrb;
  assign bus0.dinb = dinb; assign bus1.dinb = dinb;

  dualmem_param #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(BW), .RDW_MODE(0), .INIT_ZERO(1))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dualmem_param #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(BW), .RDW_MODE(1), .INIT_ZERO(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  // Reference model: word array, remaining init cycles, and the value each
  // output takes one edge after an access (q*) versus what is visible (e*).
  logic [DW-1:0] mem_m [DEPTH];
  int            init_left = DEPTH;
  logic [DW-1:0] q0a = '0, q0b = '0, q1a = '0, q1b = '0;
  logic          qva = 1'b0, qvb = 1'b0, qcol = 1'b0;
  logic [DW-1:0] e0a, e0b, e1a, e1b;
  logic          eva, evb, ecol;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [NB-1:0] we);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < NB; i++) if (we[i]) r[i*BW +: BW] = n[i*BW +: BW];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
  endtask

  task automatic port_a(input logic en, input logic [NB-1:0] we, input logic [AW-1:0] ad,
                        input logic [DW-1:0] d);
    ena = en; wea = we; addra = ad; dina = d;
  endtask

  task automatic port_b(input logic en, input logic [NB-1:0] we, input logic [AW-1:0] ad,
                        input logic [DW-1:0] d);
    enb = en; web = we; addrb = ad; dinb = d;
  endtask

  // One clock cycle: predict, clock, update model, compare every output.
  task automatic step();
    logic [DW-1:0] oa, ob, n0a, n0b, n1a, n1b;
    logic nva, nvb, ncol;
    bit acc_a, acc_b;
    acc_a = !rst && (init_left == 0) && ena;
    acc_b = !rst && (init_left == 0) && enb;
    oa  = mem_m[addra];
    ob  = mem_m[addrb];
    n0a = acc_a ? oa : q0a;
    n0b = acc_b ? ob : q0b;
    n1a = acc_a ? merge(oa, dina, wea) : q1a;
    n1b = acc_b ? merge(ob, dinb, web) : q1b;
    nva = acc_a;
    nvb = acc_b;
    ncol = acc_a && acc_b && (addra == addrb) && ((wea != '0) || (web != '0));
    @(posedge clk);
    #1;
    if (rst) begin
      init_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      n0a = '0; n0b = '0; n1a = '0; n1b = '0; nva = 1'b0; nvb = 1'b0; ncol = 1'b0;
      e0a = '0; e0b = '0; e1a = '0; e1b = '0; eva = 1'b0; evb = 1'b0; ecol = 1'b0;
    end else begin
      if (acc_b) mem_m[addrb] = merge(mem_m[addrb], dinb, web);
      if (acc_a) mem_m[addra] = merge(mem_m[addra], dina, wea);
      if (init_left > 0) init_left--;
      if (LAT == 2) begin
        e0a = q0a; e0b = q0b; e1a = q1a; e1b = q1b; eva = qva; evb = qvb; ecol = qcol;
      end else begin
        e0a = n0a; e0b = n0b; e1a = n1a; e1b = n1b; eva = nva; evb = nvb; ecol = ncol;
      end
    end
    q0a = n0a; q0b = n0b; q1a = n1a; q1b = n1b; qva = nva; qvb = nvb; qcol = ncol;
    chk("init_done0", bus0.init_done, (init_left == 0));
    chk("init_done1", bus1.init_done, (init_left == 0));
    chk("douta0", bus0.douta, e0a);
    chk("doutb0", bus0.doutb, e0b);
    chk("douta1", bus1.douta, e1a);
    chk("doutb1", bus1.doutb, e1b);
    chk("rvalida", bus0.rvalida, eva);
    chk("rvalidb", bus0.rvalidb, evb);
    chk("collision0", bus0.collision, ecol);
    chk("collision1", bus1.collision, ecol);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    addra = '0; addrb = '0; dina = '0; dinb = '0;

    // reset held two cycles, outputs cleared
    step(); step();
    rst = 1'b0;

    // partial init with attempted accesses, then reset at init cycle 9
    for (int i = 0; i < 9; i++) begin
      port_a(1'b1, '1, AW'(i), {$urandom, $urandom});
      port_b(1'b1, '1, AW'(i + 1), {$urandom, $urandom});
      step();
    end
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // full init window: accesses must be ignored, init_done rises after 16
    for (int i = 0; i < DEPTH; i++) begin
      port_a(1'b1, '1, AW'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom});
      port_b(1'b1, 8'h0F, AW'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom});
      step();
    end
    idle();

    // read every address on port A: all zero
    for (int i = 0; i < DEPTH; i++) begin
      port_a(1'b1, '0, AW'(i), '0);
      step();
    end
    idle(); step();

    // byte-lane write
    port_a(1'b1, 8'hFF, 4'h5, 64'h1122334455667788); step();
    port_a(1'b1, 8'h0F, 4'h5, 64'hAAAAAAAAAAAAAAAA); step();
    idle();
    port_b(1'b1, 8'h00, 4'h5, '0); step();
    idle(); step();
    chk("byte_write", bus0.doutb, 64'h11223344AAAAAAAA);

    // same-port read-during-write @3
    port_a(1'b1, 8'hFF, 4'h3, 64'hDEAD); step();
    idle(); step();
    chk("rdw_read_first", bus0.douta, 64'h0);
    chk("rdw_write_first", bus1.douta, 64'hDEAD);
    port_a(1'b1, 8'h00, 4'h3, '0); step();
    idle(); step();
    chk("rdw_readback", bus0.douta, 64'hDEAD);

    // cross-port write collision @7
    port_a(1'b1, 8'h01, 4'h7, 64'h0000000000000011);
    port_b(1'b1, 8'h03, 4'h7, 64'h0000000000002222);
    step();
    idle();
    if (LAT == 2) step();
    chk("collision_hi", bus0.collision, 1'b1);
    step();
    chk("collision_pulse", bus0.collision, 1'b0);
    port_a(1'b1, 8'h00, 4'h7, '0); step();
    idle(); step();
    chk("collision_data", bus0.douta[15:0], 16'h2211);

    // two reads at the same address: no collision
    port_a(1'b1, 8'h00, 4'h7, '0);
    port_b(1'b1, 8'h00, 4'h7, '0);
    step();
    idle();
    if (LAT == 2) step();
    chk("read_read_nocoll", bus0.collision, 1'b0);
    step();

    // back-to-back reads @0,1,2
    for (int i = 0; i < 3; i++) begin
      port_a(1'b1, '0, AW'(i), '0);
      step();
    end
    idle(); step(); step();

    // randomized traffic on a narrow address window to force conflicts
    for (int i = 0; i < 400; i++) begin
      port_a(1'($urandom_range(0, 3) != 0), NB'($urandom & ($urandom_range(0, 1) ? 32'hFF : 32'h0)),
             AW'($urandom_range(0, 3)), {$urandom, $urandom});
      port_b(1'($urandom_range(0, 3) != 0), NB'($urandom & ($urandom_range(0, 1) ? 32'hFF : 32'h0)),
             AW'($urandom_range(0, 3)), {$urandom, $urandom});
      step();
    end

    // final reset clears the outputs
    port_a(1'b1, '0, 4'h5, '0); step();
    idle(); step();
    rst = 1'b1;
    step();
    chk("reset_douta", bus0.douta, 64'h0);
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
